branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/branch_cond.sv | 50 +++++
 rtl/branch_predict_unit.sv | 108 ++++++++++
 tb/tb_branch_predict_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and 2-bit saturating counter helpers.
// Holds opcode/funct3 encodings for control-flow instructions, the counter
// state encodings, and a one-step saturating counter update function.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CTR_W   = 2;

  // Control-flow opcodes
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Conditional branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit predictor counter states
  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // One saturating step toward taken (+1) or not-taken (-1).
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                 input logic             taken);
    logic [CTR_W-1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_W'(ST)) nxt = ctr + CTR_W'(1);
    end else begin
      if (ctr != CTR_W'(SNT)) nxt = ctr - CTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch/jump condition evaluator (purely combinational).
// Ports:
//   instr  - instruction word (opcode and funct3 are decoded)
//   zero   - ALU equal flag
//   lt     - ALU signed less-than flag
//   ltu    - ALU unsigned less-than flag
//   boj    - control says the instruction is a branch or jump
//   taken  - resolved taken/PC-source select
module branch_cond
  import riscv_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
  input  logic               lt,
  input  logic               ltu,
  input  logic               boj,
  output logic               taken
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  // Resolve direction; reserved branch funct3 values resolve not-taken.
  always_comb begin
    taken = 1'b0;
    if (boj) begin
      case (opcode)
        OPC_BRANCH: begin
          case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
          endcase
        end
        OPC_JAL, OPC_JALR: taken = 1'b1;
        default:           taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with execute-stage resolution and redirect.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   if_pc             - fetch PC for lookup
//   if_pred_taken     - combinational prediction (counter MSB) for if_pc
//   ex_valid, ex_pc   - execute-stage valid and PC
//   ex_instr, ex_boj  - execute-stage instruction and branch/jump control
//   ex_zero/lt/ltu    - ALU flags
//   ex_pred_taken     - prediction carried with the execute instruction
//   ex_taken          - combinational resolved PC-source select
//   flush             - registered one-cycle redirect pulse
//   stat_branches     - saturating count of resolved conditional branches
//   stat_mispredicts  - saturating count of mispredicted branches
module branch_predict_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    if_pc,
  output logic               if_pred_taken,
  input  logic               ex_valid,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic               ex_boj,
  input  logic               ex_zero,
  input  logic               ex_lt,
  input  logic               ex_ltu,
  input  logic               ex_pred_taken,
  output logic               ex_taken,
  output logic               flush,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispredicts
);

  localparam int unsigned IDX_W  = $clog2(BHT_DEPTH);
  localparam int unsigned STAT_W = 32;

  logic [CTR_W-1:0] bht [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond_taken;
  logic             is_branch;
  logic             is_jump;
  logic             upd;
  logic             mispredict;
  logic             redirect;
  logic             unused_pc;

  // Word-aligned PCs: drop the two byte-offset bits when indexing.
  assign if_idx    = if_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                       ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  branch_cond u_cond (
    .instr (ex_instr),
    .zero  (ex_zero),
    .lt    (ex_lt),
    .ltu   (ex_ltu),
    .boj   (ex_boj),
    .taken (cond_taken)
  );

  assign is_branch = (ex_instr[6:0] == OPC_BRANCH);
  assign is_jump   = (ex_instr[6:0] == OPC_JAL) || (ex_instr[6:0] == OPC_JALR);

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign if_pred_taken = bht[if_idx][1];
  assign ex_taken      = ex_valid & cond_taken;

  assign upd        = ex_valid & ex_boj & is_branch;
  assign mispredict = upd & (ex_taken != ex_pred_taken);
  assign redirect   = (ex_valid & ex_boj & is_jump) | mispredict;

  // Prediction table; reset overrides any update presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= INIT_STATE;
      end
    end else if (upd) begin
      bht[ex_idx] <= ctr_step(bht[ex_idx], ex_taken);
    end
  end

  // Redirect pulse and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush            <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      flush <= redirect;
      if (upd && (stat_branches != '1)) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a table of per-cycle vectors
// with expected combinational outputs, plus a scoreboard queue for the
// registered outputs that appear after the clock edge.
module tb_branch_predict_unit;

  localparam logic [31:0] BEQ  = 32'h00628c63;
  localparam logic [31:0] BNE  = 32'h00629c63;
  localparam logic [31:0] BLT  = 32'h0062c863;
  localparam logic [31:0] BGE  = 32'h0062d863;
  localparam logic [31:0] BLTU = 32'h0052e863;
  localparam logic [31:0] BGEU = 32'h0052f863;
  localparam logic [31:0] F010 = 32'h0062a863;
  localparam logic [31:0] JAL  = 32'h008002ef;
  localparam logic [31:0] JALR = 32'h00008067;
  localparam logic [31:0] ADDI = 32'h00100093;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic        ex_boj;
  logic        ex_zero;
  logic        ex_lt;
  logic        ex_ltu;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predict_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_instr         (ex_instr),
    .ex_boj           (ex_boj),
    .ex_zero          (ex_zero),
    .ex_lt            (ex_lt),
    .ex_ltu           (ex_ltu),
    .ex_pred_taken    (ex_pred_taken),
    .ex_taken         (ex_taken),
    .flush            (flush),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, valid, boj;
    logic [31:0] instr, pc;
    logic        zero, lt, ltu, pred;
    logic [31:0] if_pc;
    logic        chk_pred;
    logic        e_taken, e_pred, e_flush;
    logic [31:0] e_br, e_mp;
  } vec_t;

  typedef struct {
    logic        flush;
    logic [31:0] br, mp;
    int          row;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic r, logic v, logic b, logic [31:0] instr,
                              logic [31:0] pc, logic z, logic l, logic lu,
                              logic p, logic [31:0] ipc, logic cp, logic et,
                              logic ep, logic ef, logic [31:0] br,
                              logic [31:0] mp);
    vec_t t;
    t.rst_n = r; t.valid = v; t.boj = b; t.instr = instr; t.pc = pc;
    t.zero = z; t.lt = l; t.ltu = lu; t.pred = p; t.if_pc = ipc;
    t.chk_pred = cp; t.e_taken = et; t.e_pred = ep; t.e_flush = ef;
    t.e_br = br; t.e_mp = mp;
    return t;
  endfunction

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n         = t.rst_n;
    ex_valid      = t.valid;
    ex_boj        = t.boj;
    ex_instr      = t.instr;
    ex_pc         = t.pc;
    ex_zero       = t.zero;
    ex_lt         = t.lt;
    ex_ltu        = t.ltu;
    ex_pred_taken = t.pred;
    if_pc         = t.if_pc;
  endtask

  // One cycle: drive on the falling edge, check combinational outputs,
  // queue registered expectations, then compare just after the rising edge.
  task automatic run_row(input vec_t t, input int row);
    exp_t e, g;
    @(negedge clk);
    drive(t);
    #1;
    check("ex_taken", row, 32'(ex_taken), 32'(t.e_taken));
    if (t.chk_pred) check("if_pred_taken", row, 32'(if_pred_taken), 32'(t.e_pred));
    e.flush = t.e_flush; e.br = t.e_br; e.mp = t.e_mp; e.row = row;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
    end else begin
      g = sb.pop_front();
      check("flush", g.row, 32'(flush), 32'(g.flush));
      check("stat_branches", g.row, stat_branches, g.br);
      check("stat_mispredicts", g.row, stat_mispredicts, g.mp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    drive(mk(0,0,0,0,0,0,0,0,0,32'h10,0,0,0,0,0,0));

    //                r v b instr pc      z l lu p if_pc  cp et ep ef br mp
    tbl.push_back(mk(0,0,0,0,    0,     0,0,0,0,32'h10, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h10, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,BEQ,  32'h10,1,0,0,0,32'h10, 1,1,0,1,1,1));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h10, 1,0,1,0,1,1));
    tbl.push_back(mk(1,1,1,BLT,  32'h20,0,1,0,0,32'h20, 1,1,0,1,2,2));
    tbl.push_back(mk(1,1,1,BLT,  32'h20,0,1,0,1,32'h20, 1,1,1,0,3,2));
    tbl.push_back(mk(1,1,1,BLT,  32'h20,0,1,0,1,32'h20, 1,1,1,0,4,2));
    tbl.push_back(mk(1,1,1,BLT,  32'h20,0,1,0,1,32'h20, 1,1,1,0,5,2));
    tbl.push_back(mk(1,1,1,BLT,  32'h20,0,0,0,1,32'h20, 1,0,1,1,6,3));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h20, 1,0,1,0,6,3));
    tbl.push_back(mk(1,1,1,BLTU, 32'h30,0,0,0,0,32'h30, 1,0,0,0,7,3));
    tbl.push_back(mk(1,1,1,BLTU, 32'h30,0,0,0,0,32'h30, 1,0,0,0,8,3));
    tbl.push_back(mk(1,1,1,BEQ,  32'h30,1,0,0,0,32'h30, 1,1,0,1,9,4));
    tbl.push_back(mk(1,1,1,BEQ,  32'h30,1,0,0,0,32'h30, 1,1,0,1,10,5));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h30, 1,0,1,0,10,5));
    tbl.push_back(mk(1,1,1,JAL,  32'h30,0,0,0,0,32'h30, 1,1,1,1,10,5));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h30, 1,0,1,0,10,5));
    tbl.push_back(mk(1,1,1,JALR, 32'h40,0,0,0,0,32'h40, 1,1,0,1,10,5));
    tbl.push_back(mk(1,1,0,JAL,  32'h40,0,0,0,0,32'h40, 1,0,0,0,10,5));
    tbl.push_back(mk(1,0,1,BEQ,  32'h40,1,0,0,0,32'h40, 1,0,0,0,10,5));
    tbl.push_back(mk(1,1,1,ADDI, 32'h40,1,0,0,1,32'h40, 1,0,0,0,10,5));
    tbl.push_back(mk(1,1,1,BNE,  32'h40,0,0,0,1,32'h40, 1,1,0,0,11,5));
    tbl.push_back(mk(1,1,1,BGE,  32'h40,0,1,0,1,32'h40, 1,0,1,1,12,6));
    tbl.push_back(mk(1,1,1,BGEU, 32'h40,0,0,0,0,32'h40, 1,1,0,1,13,7));
    tbl.push_back(mk(1,1,1,F010, 32'h40,1,1,1,0,32'h40, 1,0,1,0,14,7));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h40, 1,0,0,0,14,7));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h110,1,0,1,0,14,7));
    tbl.push_back(mk(0,1,1,BEQ,  32'h10,1,0,0,0,32'h10, 1,1,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h10, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,    0,     0,0,0,0,32'h30, 1,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    // Redirect latency and pulse width for a mispredicted beq.
    @(negedge clk);
    drive(mk(1,1,1,BEQ,32'h50,1,0,0,0,32'h50,0,0,0,0,0,0));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) drive(mk(1,0,0,0,0,0,0,0,0,32'h50,0,0,0,0,0,0));
    end while (!flush && lat < 4);
    check("flush_latency", 100, 32'(lat), 32'd1);
    @(posedge clk);
    #1;
    check("flush_width", 101, 32'(flush), 32'd0);
    check("seq_branches", 101, stat_branches, 32'd1);
    check("seq_mispredicts", 101, stat_mispredicts, 32'd1);
    check("seq_pred", 101, 32'(if_pred_taken), 32'd1);

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
